// File: rtl/led_breather_if.sv
// led_breather_if: control inputs and LED/breathe status outputs of the LED driver stage.
interface led_breather_if #(parameter int PWM_BITS = 8);
  logic en;
  logic [1:0] mode;
  logic blink_in;
  logic led;
  logic [PWM_BITS-1:0] duty;
  logic cycle_done;
  modport master (output en, mode, blink_in, input led, duty, cycle_done);
  modport slave (input en, mode, blink_in, output led, duty, cycle_done);
endinterface

// File: rtl/led_breather.sv
// led_breather: drives the board LED off/solid/breathing-PWM/follow-blink from a free-running PWM counter.
module led_breather #(
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 48828,
  parameter int HOLD_STEPS = 64
) (
  input logic clk,
  input logic rst_n,
  led_breather_if.slave bus
);
  localparam logic [1:0] RISE = 2'd0, HOLD_HI = 2'd1, FALL = 2'd2, HOLD_LO = 2'd3;
  localparam int PW = $clog2(STEP_DIV);
  localparam int HW = $clog2(HOLD_STEPS + 1);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  logic [1:0] state;
  logic [PWM_BITS-1:0] pwm_cnt, duty;
  logic [PW-1:0] presc;
  logic [HW-1:0] hold_cnt;
  logic breathe, step, hold_end, pwm_on;
  assign breathe = bus.mode == 2'b10;
  assign step = bus.en && breathe && presc == PW'(STEP_DIV - 1);
  assign hold_end = hold_cnt == HW'(HOLD_STEPS - 1);
  assign pwm_on = pwm_cnt < duty;
  assign bus.duty = duty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt        <= '0;
      bus.led        <= 1'b0;
      bus.cycle_done <= 1'b0;
      state          <= RISE;
      duty           <= '0;
      presc          <= '0;
      hold_cnt       <= '0;
    end else begin
      pwm_cnt        <= bus.en ? pwm_cnt + 1'b1 : pwm_cnt;
      bus.led        <= !bus.en ? 1'b0 : bus.mode[1] ? (bus.mode[0] ? bus.blink_in : pwm_on) : bus.mode[0];
      bus.cycle_done <= step && state == HOLD_LO && hold_end;
      // leaving breathe mode always discards the ramp so re-entry starts from duty 0
      if (!breathe) begin
        state    <= RISE;
        duty     <= '0;
        presc    <= '0;
        hold_cnt <= '0;
      end else if (bus.en) begin
        presc <= step ? '0 : presc + 1'b1;
        if (step) begin
          case (state)
            RISE: begin
              duty <= duty + 1'b1;
              if (duty == MAX - 1'b1) begin
                state    <= HOLD_HI;
                hold_cnt <= '0;
              end
            end
            HOLD_HI: begin
              hold_cnt <= hold_cnt + 1'b1;
              if (hold_end) state <= FALL;
            end
            FALL: begin
              duty <= duty - 1'b1;
              if (duty == PWM_BITS'(1)) begin
                state    <= HOLD_LO;
                hold_cnt <= '0;
              end
            end
            HOLD_LO: begin
              hold_cnt <= hold_cnt + 1'b1;
              if (hold_end) state <= RISE;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_led_breather.sv
// tb_led_breather: directed checks of reset, breathe ramp/holds, PWM compare, en freeze and mode switching.
module tb_led_breather;
  localparam int PB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  led_breather_if #(.PWM_BITS(PB)) bus ();
  led_breather #(.PWM_BITS(PB), .STEP_DIV(4), .HOLD_STEPS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // expected duty after m edges of breathing from reset: 15 up, 2 hold, 15 down, 2 hold
  function automatic int dexp(input int m);
    int s;
    s = (m / 4) % 34;
    return s <= 15 ? s : s <= 17 ? 15 : s <= 32 ? 32 - s : 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int prev;
    logic [4:0] pat;
    bus.en = 1'b1;
    bus.mode = 2'b01;
    bus.blink_in = 1'b0;
    tick(1);
    chk("reset_led", bus.led, 0);
    rst_n = 1'b1;
    tick(1);
    chk("solid_first_edge", bus.led, 1);
    tick(2);
    chk("solid_hold", bus.led, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", bus.led, 0);
    chk("async_rst_duty", bus.duty, 0);
    chk("async_rst_cd", bus.cycle_done, 0);
    bus.mode = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    tick(2);
    chk("off_led", bus.led, 0);
    chk("off_duty", bus.duty, 0);
    #2 rst_n = 1'b0;
    #1 bus.mode = 2'b10;
    @(negedge clk) rst_n = 1'b1;
    prev = 0;
    for (int n = 1; n <= 275; n++) begin
      tick(1);
      chk("ramp_duty", bus.duty, dexp(n));
      chk("ramp_led", bus.led, ((n - 1) % 16) < dexp(n - 1));
      chk("ramp_cd", bus.cycle_done, (n % 136) == 0);
      chk("no_wrap", (int'(bus.duty) - prev >= -1) && (int'(bus.duty) - prev <= 1), 1);
      prev = int'(bus.duty);
    end
    #2 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick(30);
    chk("pre_freeze_duty", bus.duty, 7);
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("freeze_led", bus.led, 0);
      chk("freeze_duty", bus.duty, 7);
      chk("freeze_cd", bus.cycle_done, 0);
    end
    bus.en = 1'b1;
    tick(1);
    chk("resume_duty7", bus.duty, 7);
    tick(1);
    chk("resume_duty8", bus.duty, 8);
    tick(3);
    chk("resume_duty8_hold", bus.duty, 8);
    tick(1);
    chk("resume_duty9", bus.duty, 9);
    bus.mode = 2'b11;
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      bus.blink_in = pat[i];
      tick(1);
      chk("follow_led", bus.led, pat[i]);
      chk("follow_duty", bus.duty, 0);
      chk("follow_cd", bus.cycle_done, 0);
    end
    bus.mode = 2'b10;
    tick(3);
    chk("reenter_duty0", bus.duty, 0);
    tick(1);
    chk("reenter_duty1", bus.duty, 1);
    tick(4);
    chk("reenter_duty2", bus.duty, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midramp_rst_duty", bus.duty, 0);
    chk("midramp_rst_led", bus.led, 0);
    chk("midramp_rst_cd", bus.cycle_done, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
